// File: rtl/krnl_partialknn_mem_pkg.sv
// Shared definitions for the partialKnn local-store buffers.
// Holds the read-latency bounds, the clear-sequencer state type and a byte-merge helper.
package krnl_partialknn_mem_pkg;

  localparam int MinReadLatency = 1;
  localparam int MaxReadLatency = 4;

  // The merge helper works on the widest supported word; callers zero-extend and slice.
  localparam int MaxDataWidth = 2048;

  typedef logic [MaxDataWidth-1:0]   merge_word_t;
  typedef logic [MaxDataWidth/8-1:0] merge_be_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clear_state_e;

  function automatic merge_word_t byte_merge(input merge_word_t word,
                                             input merge_word_t data,
                                             input merge_be_t   be);
    merge_word_t res;
    res = word;
    for (int i = 0; i < MaxDataWidth / 8; i++) begin
      if (be[i]) res[8*i +: 8] = data[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/krnl_partialknn_local_buf_2p_ram.sv
// Bare simple-dual-port array: registered read, per-byte write enable, no reset.
// Read-before-write on a shared address; the wrapper applies write-first forwarding.
module krnl_partialknn_local_buf_2p_ram #(
  parameter int DataWidth  = 256,
  parameter int Depth      = 2048,
  parameter int IndexWidth = 11
) (
  input  logic                   clk,
  input  logic                   rd_en_i,
  input  logic [IndexWidth-1:0]  rd_idx_i,
  output logic [DataWidth-1:0]   rd_data_o,
  input  logic                   wr_en_i,
  input  logic [IndexWidth-1:0]  wr_idx_i,
  input  logic [DataWidth/8-1:0] wr_be_i,
  input  logic [DataWidth-1:0]   wr_data_i
);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [DataWidth-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (rd_en_i) rd_data_q <= mem_q[rd_idx_i];
    if (wr_en_i) begin
      for (int b = 0; b < DataWidth / 8; b++) begin
        if (wr_be_i[b]) mem_q[wr_idx_i][8*b +: 8] <= wr_data_i[8*b +: 8];
      end
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/krnl_partialknn_local_buf_2p.sv
// Two-port local buffer for partialKnn kernels: write-first forwarding, range masking,
// a ReadLatency-deep read pipeline with valid strobe, and a sweep that zeroes the array.
module krnl_partialknn_local_buf_2p
  import krnl_partialknn_mem_pkg::*;
#(
  parameter int DataWidth    = 256,
  parameter int AddressRange = 2048,
  parameter int AddressWidth = 11,
  parameter int ReadLatency  = 2   // MinReadLatency..MaxReadLatency
) (
  input  logic                    clk,
  input  logic                    reset,
  // Reads are fire-and-forget: no backpressure, q0_valid pulses once per ce0 cycle.
  input  logic [AddressWidth-1:0] address0,
  input  logic                    ce0,
  output logic [DataWidth-1:0]    q0,
  output logic                    q0_valid,
  input  logic [AddressWidth-1:0] address1,
  input  logic                    ce1,
  input  logic                    we1,
  input  logic [DataWidth-1:0]    d1,
  input  logic [DataWidth/8-1:0]  be1,
  input  logic                    clear_start,
  output logic                    clear_busy,
  output clear_state_e            dbg_state_o
);

  localparam int BeWidth    = DataWidth / 8;
  localparam int IndexWidth = (AddressRange > 1) ? $clog2(AddressRange) : 1;
  localparam logic [AddressWidth:0]   RangeLimit = (AddressWidth + 1)'(AddressRange);
  localparam logic [AddressWidth-1:0] LastAddr   = AddressWidth'(AddressRange - 1);

  clear_state_e            state_q, state_d;
  logic [AddressWidth-1:0] cnt_q, cnt_d;

  logic                    rd_in_range, wr_in_range;
  logic                    ram_rd_en;
  logic                    wr_en;
  logic [AddressWidth-1:0] wr_addr;
  logic [BeWidth-1:0]      wr_be;
  logic [DataWidth-1:0]    wr_data;
  logic                    fwd_hit;
  logic [DataWidth-1:0]    ram_rd_data;

  // Stage 1 sits alongside the RAM output register.
  logic                    s1_valid_q;
  logic                    s1_zero_q;
  logic                    s1_hit_q;
  logic [BeWidth-1:0]      s1_be_q;
  logic [DataWidth-1:0]    s1_d_q;
  logic [DataWidth-1:0]    s1_data;
  merge_word_t             s1_merged;

  assign rd_in_range = ({1'b0, address0} < RangeLimit);
  assign wr_in_range = ({1'b0, address1} < RangeLimit);
  assign ram_rd_en   = reset && ce0 && rd_in_range;

  // Clear sequencer
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == LastAddr) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AddressWidth'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign clear_busy  = (state_q == ST_CLEAR);
  assign dbg_state_o = state_q;

  // The sweep owns the write port while clearing; external writes are dropped.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = address1;
    wr_be   = be1;
    wr_data = d1;
    if (!reset) begin
      wr_en = 1'b0;
    end else if (state_q == ST_CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = cnt_q;
      wr_be   = '1;
      wr_data = '0;
    end else if (ce1 && we1 && wr_in_range) begin
      wr_en = 1'b1;
    end
  end

  assign fwd_hit = ram_rd_en && wr_en && (wr_addr == address0);

  krnl_partialknn_local_buf_2p_ram #(
    .DataWidth  (DataWidth),
    .Depth      (AddressRange),
    .IndexWidth (IndexWidth)
  ) u_ram (
    .clk       (clk),
    .rd_en_i   (ram_rd_en),
    .rd_idx_i  (address0[IndexWidth-1:0]),
    .rd_data_o (ram_rd_data),
    .wr_en_i   (wr_en),
    .wr_idx_i  (wr_addr[IndexWidth-1:0]),
    .wr_be_i   (wr_be),
    .wr_data_i (wr_data)
  );

  // Side info only reloads on a read, so the merged value holds between reads;
  // s1_zero_q resets high so q0 reads zero before the first read lands.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_zero_q  <= 1'b1;
      s1_hit_q   <= 1'b0;
      s1_be_q    <= '0;
      s1_d_q     <= '0;
    end else begin
      s1_valid_q <= ce0;
      if (ce0) begin
        s1_zero_q <= !rd_in_range;
        s1_hit_q  <= fwd_hit;
        s1_be_q   <= wr_be;
        s1_d_q    <= wr_data;
      end
    end
  end

  assign s1_merged = byte_merge(merge_word_t'(ram_rd_data), merge_word_t'(s1_d_q),
                                merge_be_t'(s1_be_q));

  always_comb begin
    s1_data = ram_rd_data;
    if (s1_zero_q)     s1_data = '0;
    else if (s1_hit_q) s1_data = s1_merged[DataWidth-1:0];
  end

  generate
    if (ReadLatency <= 1) begin : g_lat1
      assign q0       = s1_data;
      assign q0_valid = s1_valid_q;
    end else begin : g_latn
      logic [ReadLatency-2:0] pv_q;
      logic [DataWidth-1:0]   pd_q [ReadLatency-1];

      // Data registers load only with their valid, so the last stage holds the last result.
      always_ff @(posedge clk) begin
        if (!reset) begin
          pv_q <= '0;
          for (int i = 0; i < ReadLatency - 1; i++) pd_q[i] <= '0;
        end else begin
          pv_q[0] <= s1_valid_q;
          if (s1_valid_q) pd_q[0] <= s1_data;
          for (int i = 1; i < ReadLatency - 1; i++) begin
            pv_q[i] <= pv_q[i-1];
            if (pv_q[i-1]) pd_q[i] <= pd_q[i-1];
          end
        end
      end

      assign q0       = pd_q[ReadLatency-2];
      assign q0_valid = pv_q[ReadLatency-2];
    end
  endgenerate

endmodule

// File: doc/krnl_partialknn_local_buf_2p.md
# krnl_partialknn_local_buf_2p

Parametrised simple-dual-port local buffer for the partialKnn kernels, the next generation of the single-port URAM local-store wrapper. Provides one read port and one write port per cycle, per-byte write enables, a configurable read-pipeline depth with an output valid strobe, write-first collision forwarding, and a hardware clear sequencer that zeroes the whole array. Sits between a kernel's compute pipeline and its local point or distance storage, replacing the per-kernel single-port wrappers.

## Interface
- DataWidth, 256: word width in bits; multiple of 8.
- AddressRange, 2048: number of words; need not be a power of two.
- AddressWidth, 11: address width; at least clog2(AddressRange).
- ReadLatency, 2: cycles from read issue to data; legal range 1..4.
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- address0  in  AddressWidth  read address.
- ce0  in  1  read enable.
- q0  out  DataWidth  read data.
- q0_valid  out  1  one-cycle strobe marking the cycle q0 carries new read data.
- address1  in  AddressWidth  write address.
- ce1  in  1  write-port enable.
- we1  in  1  write enable; a write occurs only when ce1 and we1 are both high.
- d1  in  DataWidth  write data.
- be1  in  DataWidth/8  byte enables; bit i gates d1[8i+7:8i].
- clear_start  in  1  single-cycle request to zero the array.
- clear_busy  out  1  high while the clear sweep is running.

## Operation
- Write: when ce1 and we1 are high and address1 < AddressRange, the bytes selected by be1 update; unselected bytes keep their value. be1 = 0 is a no-op. Out-of-range writes are dropped.
- Read: ce0 with address0 < AddressRange returns the word. An out-of-range read returns all-zero data but still produces a q0_valid strobe.
- Collision (read and write to the same address in the same cycle): write-first. The read returns the stored word with the enabled bytes of d1 merged in.
- A write in a later cycle does not alter a read already in flight.
- Clear FSM, two states:
  - IDLE -> CLEAR on clear_start. clear_start is ignored while in CLEAR.
  - In CLEAR, an internal counter runs 0..AddressRange-1 and writes all-zero words, one per cycle.
  - CLEAR -> IDLE after the write to AddressRange-1; the counter returns to 0.
- While in CLEAR, external writes are dropped silently. Reads are still served and return the current, partly cleared contents. A read and the sweep hitting the same address in the same cycle follows write-first, so it returns zero.
- Reset:
  - FSM -> IDLE, counter = 0, every pipeline-stage valid = 0.
  - q0 = 0, q0_valid = 0, clear_busy = 0.
  - Array contents are not reset. A reset during CLEAR leaves the array partly cleared.
- q0 holds its last value between reads. Only q0_valid pulses.

## Timing
- A read issued at cycle t drives q0 and q0_valid at t+ReadLatency. Back-to-back reads give one result per cycle.
- A write at cycle t is visible to a read issued at t (write-first) and to any later read.
- clear_start high at cycle t: clear_busy goes high at t+1 and stays high for exactly AddressRange cycles. The sweep writes address k at cycle t+1+k.
- A write arriving in the same cycle as clear_start is performed, and is then overwritten by the sweep.
- The cycle after reset is released behaves as IDLE with an empty read pipeline.

## Structure
- Shared package krnl_partialknn_mem_pkg:
  - ReadLatency bounds (min 1, max 4).
  - Byte-merge function (word, data, byte-enable) -> word.
  - Clear FSM state enum {ST_IDLE, ST_CLEAR}.
- Sub-module krnl_partialknn_local_buf_2p_ram:
  - Bare inferred URAM array with registered read, byte-write enable, no reset.
- The top level holds:
  - collision forwarding;
  - the valid and data pipeline of ReadLatency-1 extra stages;
  - out-of-range masking;
  - the clear FSM and its counter.

## Test plan
- Defaults. Write 0xA5-filled word to address 5 with be1 all ones, then read address 5 -> q0 = 0xA5 pattern and q0_valid exactly 2 cycles after ce0.
- Byte mask. Address 7 holds all ones; write d1 = 0 with be1 = 0x...0F -> a later read returns the word with bytes 0..3 zero and all other bytes 0xFF.
- Collision. Address 9 holds 0x11; in one cycle write 0x22 (full be1) and read address 9 -> q0 = 0x22. A read of address 9 issued one cycle before the write returns 0x11.
- Clear. Fill addresses 0..15 (AddressRange = 16) with nonzero data, pulse clear_start -> clear_busy high for 16 cycles; external writes during the sweep are dropped; every later read returns 0.
- Reset mid-operation. Assert reset during the CLEAR sweep and with reads in flight -> next cycle q0 = 0, q0_valid = 0, clear_busy = 0; the in-flight reads produce no strobe.
- Out of range, AddressRange = 1000. Write to 1000, then read 1000 -> q0 = 0 with a q0_valid strobe; address 999 is unaffected.
